mdbrot_pixel_dispatcher: RTL and testbench

//  Raster initiator for the Mandelbrot iteration core. Walks every 160x120 pixel, converts (x,y) to sign-magnitude
//  Q11.20 c=(cre,cim), issues one request per pixel to the core, collects the escape iteration count, maps it to a
//  3-bit colour and drives a one-cycle VGA plot strobe. Sits between the top level (start/done) and the VGA adapter.

---
 rtl/mdbrot_pkg.sv | 44 ++++
 rtl/mdbrot_coord_gen.sv | 69 ++++++
 rtl/mdbrot_pixel_dispatcher.sv | 142 ++++++++++++++
 tb/tb_mdbrot_pixel_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdbrot_pkg.sv
// Shared types, raster/fixed-point constants and helpers for the Mandelbrot pixel dispatcher.
package mdbrot_pkg;

  typedef logic [31:0] fix_t;

  localparam int   FIX_W     = 32;
  localparam int   FRAC_BITS = 20;
  localparam int   SCREEN_W  = 160;
  localparam int   SCREEN_H  = 120;
  localparam int   ITER_W    = 8;
  localparam logic [ITER_W-1:0] MAX_ITER = 8'd255;

  localparam fix_t X_START = fix_t'(-2621440);
  localparam fix_t X_STEP  = fix_t'(22938);
  localparam fix_t Y_START = fix_t'(-1048576);
  localparam fix_t Y_STEP  = fix_t'(17476);

  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_PLOT,
    ST_DONE
  } state_t;

  // Two's complement to sign-magnitude; zero stays all-zero so there is no negative zero.
  function automatic fix_t to_sign_mag(input fix_t v);
    fix_t mag;
    mag = v[FIX_W-1] ? (~v + fix_t'(1)) : v;
    return v[FIX_W-1] ? {1'b1, mag[FIX_W-2:0]} : v;
  endfunction

  function automatic colour_t iter_colour(input logic [ITER_W-1:0] it);
    if (it == MAX_ITER)
      return 3'b000;
    else if (it[2:0] == 3'b000)
      return 3'b111;
    else
      return it[2:0];
  endfunction

endpackage

// File: rtl/mdbrot_coord_gen.sv
// Raster walker: x inner / y outer pixel counters with matching two's-complement cre/cim accumulators.
module mdbrot_coord_gen
  import mdbrot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       step_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output fix_t       cre_o,
  output fix_t       cim_o,
  output logic       last_o
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  fix_t       cre_q, cre_d;
  fix_t       cim_q, cim_d;
  logic       x_wrap;

  assign x_wrap = (x_q == 8'(SCREEN_W - 1));
  assign last_o = x_wrap && (y_q == 7'(SCREEN_H - 1));

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    x_d   = x_q;
    y_d   = y_q;
    cre_d = cre_q;
    cim_d = cim_q;
    if (clear_i || (step_i && last_o)) begin
      x_d   = '0;
      y_d   = '0;
      cre_d = X_START;
      cim_d = Y_START;
    end else if (step_i) begin
      if (x_wrap) begin
        x_d   = '0;
        y_d   = y_q + 7'd1;
        cre_d = X_START;
        cim_d = cim_q + Y_STEP;
      end else begin
        x_d   = x_q + 8'd1;
        cre_d = cre_q + X_STEP;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      cre_q <= X_START;
      cim_q <= Y_START;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      cre_q <= cre_d;
      cim_q <= cim_d;
    end
  end

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign cre_o = cre_q;
  assign cim_o = cim_q;

endmodule

// File: rtl/mdbrot_pixel_dispatcher.sv
// Frame FSM: one request per pixel to the iteration core, colour mapping, VGA plot strobe.
// Optional per-frame statistics ports are enabled by defining MDBROT_DISPATCH_STATS_EN.
module mdbrot_pixel_dispatcher
  import mdbrot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [FIX_W-1:0]  req_cre,
  output logic [FIX_W-1:0]  req_cim,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [ITER_W-1:0] rsp_iter,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour,
  output logic              vga_plot
`ifdef MDBROT_DISPATCH_STATS_EN
  ,
  output logic [14:0]       stat_inside,
  output logic [31:0]       stat_cycles
`endif
);

  state_t     state_q;
  logic       busy_q, done_q, req_valid_q, rsp_ready_q, plot_q;
  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  colour_t    colour_q;

  logic       clear, step, last;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  fix_t       cur_cre, cur_cim;

  assign clear = (state_q == ST_IDLE) && start;
  assign step  = (state_q == ST_PLOT);

  mdbrot_coord_gen u_coord (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .step_i  (step),
    .x_o     (cur_x),
    .y_o     (cur_y),
    .cre_o   (cur_cre),
    .cim_o   (cur_cim),
    .last_o  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      colour_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q     <= ST_ISSUE;
          busy_q      <= 1'b1;
          req_valid_q <= 1'b1;
        end
        ST_ISSUE: if (req_ready) begin
          state_q     <= ST_WAIT;
          req_valid_q <= 1'b0;
          rsp_ready_q <= 1'b1;
        end
        ST_WAIT: if (rsp_valid) begin
          state_q     <= ST_PLOT;
          rsp_ready_q <= 1'b0;
          plot_q      <= 1'b1;
          vga_x_q     <= cur_x;
          vga_y_q     <= cur_y;
          colour_q    <= iter_colour(rsp_iter);
        end
        ST_PLOT: begin
          plot_q <= 1'b0;
          if (last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= ST_ISSUE;
            req_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Coordinates only leave the block while a request is offered; otherwise the bus reads zero.
  assign req_cre    = req_valid_q ? to_sign_mag(cur_cre) : '0;
  assign req_cim    = req_valid_q ? to_sign_mag(cur_cim) : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign req_valid  = req_valid_q;
  assign rsp_ready  = rsp_ready_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;

`ifdef MDBROT_DISPATCH_STATS_EN
  logic [14:0] inside_q;
  logic [31:0] cycles_q;

  // Cycle count covers ISSUE/WAIT/PLOT, i.e. every edge from accepted start up to the one raising done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inside_q <= '0;
      cycles_q <= '0;
    end else if (clear) begin
      inside_q <= '0;
      cycles_q <= '0;
    end else begin
      if ((state_q == ST_WAIT) && rsp_valid && (rsp_iter == MAX_ITER))
        inside_q <= inside_q + 15'd1;
      if ((state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_PLOT))
        cycles_q <= cycles_q + 32'd1;
    end
  end

  assign stat_inside = inside_q;
  assign stat_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_mdbrot_pixel_dispatcher.sv
// Randomized self-checking bench for mdbrot_pixel_dispatcher against a raster/colour reference model.
module tb_mdbrot_pixel_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, req_valid, req_ready, rsp_valid, rsp_ready, vga_plot;
  logic [31:0] req_cre, req_cim;
  logic [7:0]  rsp_iter;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
`ifdef MDBROT_DISPATCH_STATS_EN
  logic [14:0] stat_inside;
  logic [31:0] stat_cycles;
`endif

  always #5 clk = ~clk;

  mdbrot_pixel_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cre    (req_cre),
    .req_cim    (req_cim),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_iter   (rsp_iter),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
`ifdef MDBROT_DISPATCH_STATS_EN
    ,
    .stat_inside(stat_inside),
    .stat_cycles(stat_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: pixel n sits at (n%160, n/160); c = start + index*step, then sign-magnitude.
  function automatic logic [31:0] sm(input longint v);
    logic [31:0] m;
    if (v < 0) begin
      m = 32'(-v);
      return {1'b1, m[30:0]};
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] exp_cre(input int idx);
    return sm(-64'sd2621440 + longint'(idx % 160) * 22938);
  endfunction

  function automatic logic [31:0] exp_cim(input int idx);
    return sm(-64'sd1048576 + longint'(idx / 160) * 17476);
  endfunction

  function automatic logic [2:0] exp_colour(input int it);
    if (it == 255) return 3'd0;
    if (it % 8 == 0) return 3'd7;
    return 3'(it % 8);
  endfunction

  // Stimulus knobs, written only by the main sequence.
  int unsigned rdy_prob = 100, val_prob = 100;
  bit          noise = 0, directed = 1;

  // Agent/model state, written only by the agent process.
  int          req_idx = 0, plot_idx = 0, done_cnt = 0, frame_plots = 0;
  int          rsp_cnt = 0, inside_cnt = 0, last_inside = 0, cyc_cnt = 0, last_cyc = 0;
  int          outstanding = 0, last_x = 0, last_y = 0;
  bit          prev_stall = 0, prev_plot = 0, prev_done = 0, have_plot = 0;
  logic [31:0] prev_cre, prev_cim;
  logic [2:0]  last_c;
  logic [2:0]  colour_q[$];

  initial begin
    int dir_tab[4];
    int it;
    logic [2:0] c;
    dir_tab = '{255, 8, 5, 3};
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_iter  = '0;
    forever begin
      @(posedge clk);
      #1;
      req_ready = ($urandom_range(99) < rdy_prob);
      if (rsp_ready && !rst) begin
        rsp_valid = ($urandom_range(99) < val_prob);
        if (rsp_valid) begin
          if (directed && rsp_cnt < 4) it = dir_tab[rsp_cnt];
          else it = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(254));
          rsp_iter = 8'(it);
          colour_q.push_back(exp_colour(it));
          rsp_cnt++;
          if (it == 255) inside_cnt++;
        end
      end else begin
        rsp_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        rsp_iter  = 8'($urandom);
      end

      @(negedge clk);
      if (rst) begin
        req_idx = 0; plot_idx = 0; rsp_cnt = 0; inside_cnt = 0; cyc_cnt = 0;
        outstanding = 0; prev_stall = 0; prev_plot = 0; prev_done = 0; have_plot = 0;
        colour_q.delete();
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", req_valid, 1);
          check("stall_cre_stable", req_cre, prev_cre);
          check("stall_cim_stable", req_cim, prev_cim);
        end
        if (req_valid) begin
          check("req_cre", req_cre, exp_cre(req_idx));
          check("req_cim", req_cim, exp_cim(req_idx));
          if (req_ready) begin
            check("one_outstanding", outstanding, 0);
            outstanding++;
            req_idx++;
          end
        end
        if (rsp_ready) check("rsp_ready_only_waiting", outstanding, 1);
        if (rsp_valid && rsp_ready) outstanding--;
        if (vga_plot) begin
          check("plot_single_cycle", prev_plot, 0);
          check("plot_x", vga_x, plot_idx % 160);
          check("plot_y", vga_y, plot_idx / 160);
          if (colour_q.size() == 0) check("plot_expected", 0, 1);
          else begin
            c = colour_q.pop_front();
            check("plot_colour", vga_colour, c);
          end
          last_x = plot_idx % 160; last_y = plot_idx / 160; last_c = vga_colour;
          have_plot = 1;
          plot_idx++;
        end else if (have_plot) begin
          check("hold_x", vga_x, last_x);
          check("hold_y", vga_y, last_y);
          check("hold_colour", vga_colour, last_c);
        end
        if (done) begin
          check("done_single_cycle", prev_done, 0);
          check("done_after_last_pixel", plot_idx, 19200);
          done_cnt++;
          frame_plots = plot_idx;
          last_inside = inside_cnt;
          last_cyc = cyc_cnt;
          plot_idx = 0; req_idx = 0; inside_cnt = 0; cyc_cnt = 0;
        end
        if (busy && !done) cyc_cnt++;
        prev_stall = req_valid && !req_ready;
        prev_cre = req_cre;
        prev_cim = req_cim;
        prev_plot = vga_plot;
        prev_done = done;
      end
    end
  end

  task automatic wait_plot();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vga_plot) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("plot_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_rsp_ready"}, rsp_ready, 0);
    check({tag, "_req_cre"}, req_cre, 0);
    check({tag, "_req_cim"}, req_cim, 0);
    check({tag, "_vga_x"}, vga_x, 0);
    check({tag, "_vga_y"}, vga_y, 0);
    check({tag, "_vga_colour"}, vga_colour, 0);
    check({tag, "_vga_plot"}, vga_plot, 0);
`ifdef MDBROT_DISPATCH_STATS_EN
    check({tag, "_stat_inside"}, stat_inside, 0);
    check({tag, "_stat_cycles"}, stat_cycles, 0);
`endif
  endtask

  initial begin
    bit hit, got_done;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // First frame: directed colours, first/second request coordinates, 10-cycle stall.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    check("start_req_valid", req_valid, 1);
    check("start_busy", busy, 1);
    check("first_cre", req_cre, 32'h8028_0000);
    check("first_cim", req_cim, 32'h8010_0000);
    wait_plot();
    check("p0_x", vga_x, 0);
    check("p0_colour", vga_colour, 3'd0);
    rdy_prob = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      check("stall_req_valid", req_valid, 1);
      check("stall_no_plot", vga_plot, 0);
      check("second_cre", req_cre, 32'h8027_A666);
      check("second_cim", req_cim, 32'h8010_0000);
    end
    rdy_prob = 100;
    wait_plot();
    check("p1_x", vga_x, 1);
    check("p1_colour", vga_colour, 3'd7);
    wait_plot();
    check("p2_x", vga_x, 2);
    check("p2_colour", vga_colour, 3'd5);
    wait_plot();
    check("p3_x", vga_x, 3);
    check("p3_y", vga_y, 0);
    check("p3_colour", vga_colour, 3'd3);

    // Random handshakes with stray rsp_valid, then reset while a response is pending.
    directed = 0; rdy_prob = 60; val_prob = 40; noise = 1;
    hit = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (plot_idx >= 500 && rsp_ready && rsp_valid) begin
        hit = 1;
        break;
      end
    end
    check("reached_pixel_500", hit, 1);
    #1 rst = 1'b1;
    #1 check_all_zero("midframe_reset");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_after_reset_busy", busy, 0);
      check("idle_after_reset_req", req_valid, 0);
    end
    check("no_done_after_abort", done_cnt, 0);

    // Full frame, zero-latency responder, stray rsp_valid and a start pulse mid-frame.
    rdy_prob = 100; val_prob = 100; noise = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    check("restart_cre", req_cre, 32'h8028_0000);
    check("restart_cim", req_cim, 32'h8010_0000);
    got_done = 0;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      #2;
      if (i == 3000) begin
        start = 1'b1;
        check("busy_mid_frame", busy, 1);
      end
      if (i == 3001) start = 1'b0;
      if (done_cnt > 0) begin
        got_done = 1;
        break;
      end
    end
    check("frame_done_seen", got_done, 1);
    check("busy_after_done", busy, 0);
    repeat (3) @(posedge clk);
    #2;
    check("done_pulses_once", done_cnt, 1);
    check("done_low_after", done, 0);
    check("frame_plots", frame_plots, 19200);
    check("last_plot_x", last_x, 159);
    check("last_plot_y", last_y, 119);
`ifdef MDBROT_DISPATCH_STATS_EN
    check("stat_inside", stat_inside, last_inside);
    check("stat_cycles", stat_cycles, last_cyc);
    check("stat_cycles_zero_latency", stat_cycles, 3 * 19200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
